manch_encoder: RTL and testbench

MANCH_ENCODER -- requirements
Module: manch_encoder

---
 rtl/manch_defs.sv | 24 ++
 rtl/manch_half_timer.sv | 36 +++
 rtl/manch_encoder.sv | 113 +++++++++++
 tb/tb_manch_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manch_defs.sv
// Definitions shared by the Manchester encoder and decoder: FSM state encodings,
// line polarity, and counter-width helpers.
package manch_defs;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_FIRST_HALF  = 2'd1,
      ST_SECOND_HALF = 2'd2
   } manch_state_e;

   // IEEE 802.3 polarity: a '1' is sent low-then-high.
   localparam logic BIT1_FIRST_HALF = 1'b0;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic half_level(input logic bit_v, input logic second_half);
      logic first_lvl;
      first_lvl = bit_v ? BIT1_FIRST_HALF : ~BIT1_FIRST_HALF;
      return second_half ? ~first_lvl : first_lvl;
   endfunction

endpackage

// File: rtl/manch_half_timer.sv
// Half-bit timer: counts 0..CLK_PER_HALF-1 while enabled, pulses term on the last count.
// term is combinational from the count, so no extra latency; the counter holds at 0 when disabled.
module manch_half_timer
   import manch_defs::*;
#(
   parameter int CLK_PER_HALF = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic term
);

   localparam int CW = cnt_w(CLK_PER_HALF);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_HALF - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      term  = en && (cnt_q == LAST);
      if (en) begin
         cnt_d = term ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/manch_encoder.sv
// Serialises DATA_W-bit words MSB first onto a Manchester line; first half-bit appears 1 cycle after accept.
// din_ready is high only in IDLE or on the final cycle of a word, so back-to-back words leave no gap.
module manch_encoder
   import manch_defs::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLK_PER_HALF = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dataout,
   output logic              busy,
   output logic              tx_done
);

   localparam int BW = cnt_w(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   manch_state_e      state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              dataout_q, dataout_d;
   logic              tx_done_q, tx_done_d;

   logic half_term;
   logic word_end;
   logic accept;

   manch_half_timer #(
      .CLK_PER_HALF(CLK_PER_HALF)
   ) u_half_timer (
      .clk (clk),
      .rst (rst),
      .en  (state_q != ST_IDLE),
      .term(half_term)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      dataout_d = 1'b0;

      word_end  = (state_q == ST_SECOND_HALF) && half_term && (bit_cnt_q == LAST_BIT);
      din_ready = !rst && ((state_q == ST_IDLE) || word_end);
      accept    = din_valid && din_ready;
      tx_done_d = word_end;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_FIRST_HALF;
               shift_d   = din;
               bit_cnt_d = '0;
            end
         end
         ST_FIRST_HALF: begin
            if (half_term) begin
               state_d = ST_SECOND_HALF;
            end
         end
         ST_SECOND_HALF: begin
            if (word_end) begin
               if (accept) begin
                  state_d   = ST_FIRST_HALF;
                  shift_d   = din;
                  bit_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (half_term) begin
               state_d   = ST_FIRST_HALF;
               shift_d   = shift_q << 1;
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level is registered from the next state so it lines up with the state change.
      case (state_d)
         ST_FIRST_HALF:  dataout_d = half_level(shift_d[DATA_W-1], 1'b0);
         ST_SECOND_HALF: dataout_d = half_level(shift_d[DATA_W-1], 1'b1);
         default:        dataout_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dataout_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         dataout_q <= dataout_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign dataout = dataout_q;
   assign busy    = (state_q != ST_IDLE);
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_manch_encoder.sv
// Bench for manch_encoder: per-cycle comparison against a word/position line model,
// plus literal waveform, timing and loopback-decode expectations.
module tb_manch_encoder;

   logic       clk;
   logic       rst_a  [2];
   logic [7:0] din_a  [2];
   logic       vld_a  [2];
   logic       rdy_a  [2];
   logic       out_a  [2];
   logic       busy_a [2];
   logic       done_a [2];

   manch_encoder #(.DATA_W(8), .CLK_PER_HALF(4)) dut4 (
      .clk(clk), .rst(rst_a[0]), .din(din_a[0]), .din_valid(vld_a[0]),
      .din_ready(rdy_a[0]), .dataout(out_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]));

   manch_encoder #(.DATA_W(8), .CLK_PER_HALF(1)) dut1 (
      .clk(clk), .rst(rst_a[1]), .din(din_a[1]), .din_valid(vld_a[1]),
      .din_ready(rdy_a[1]), .dataout(out_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: word being sent and cycle position within it (-1 = idle).
   int         pos      [2];
   logic [7:0] word     [2];
   logic       mdone    [2];
   int         acc_n    [2];
   int         acc_edge [2];
   int         tx_cnt   [2];
   int         tx_rel   [2];
   int         cyc;
   logic       rec0 [$];
   logic       rec1 [$];
   int         n_chk;
   int         n_err;

   function automatic int hlf(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      int   t;
      int   h;
      logic b;
      logic e_out;
      logic e_rdy;
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         h     = hlf(k);
         t     = 16 * h;
         e_rdy = !rst_a[k] && (pos[k] < 0 || pos[k] == t - 1);
         if (rst_a[k]) begin
            pos[k]   = -1;
            mdone[k] = 1'b0;
         end else begin
            mdone[k] = (pos[k] == t - 1);
            if (vld_a[k] && e_rdy) begin
               word[k]     = din_a[k];
               pos[k]      = 0;
               acc_n[k]    = acc_n[k] + 1;
               acc_edge[k] = cyc;
            end else if (pos[k] == t - 1) begin
               pos[k] = -1;
            end else if (pos[k] >= 0) begin
               pos[k] = pos[k] + 1;
            end
         end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         h     = hlf(k);
         t     = 16 * h;
         e_rdy = !rst_a[k] && (pos[k] < 0 || pos[k] == t - 1);
         if (pos[k] < 0) begin
            e_out = 1'b0;
         end else begin
            b     = word[k][7 - pos[k] / (2 * h)];
            e_out = (((pos[k] / h) % 2) == 0) ? ~b : b;
         end
         check($sformatf("dut%0d dataout", k), 32'(out_a[k]), 32'(e_out));
         check($sformatf("dut%0d busy", k), 32'(busy_a[k]), 32'(pos[k] >= 0));
         check($sformatf("dut%0d tx_done", k), 32'(done_a[k]), 32'(mdone[k]));
         check($sformatf("dut%0d din_ready", k), 32'(rdy_a[k]), 32'(e_rdy));
         if (pos[k] >= 0) begin
            if (k == 0) rec0.push_back(out_a[k]);
            else        rec1.push_back(out_a[k]);
         end
         if (done_a[k] === 1'b1) begin
            tx_cnt[k] = tx_cnt[k] + 1;
            tx_rel[k] = cyc - acc_edge[k] + 1;
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] w, input bit keep);
      int  n0;
      bit  ok;
      din_a[k] = w;
      vld_a[k] = 1'b1;
      n0 = acc_n[k];
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (acc_n[k] != n0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check($sformatf("dut%0d accept timeout", k), 32'd0, 32'd1);
      if (!keep) vld_a[k] = 1'b0;
   endtask

   task automatic idle_wait(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (pos[k] < 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check($sformatf("dut%0d idle timeout", k), 32'd0, 32'd1);
      repeat (2) cycle();
   endtask

   // Level at the start of each of 16 half-bits, MSB-first.
   function automatic logic [15:0] halves_of(input int k, input int base);
      logic [15:0] r;
      int idx;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         idx = base + i * hlf(k);
         if (k == 0) r[15-i] = (idx < rec0.size()) ? rec0[idx] : 1'b0;
         else        r[15-i] = (idx < rec1.size()) ? rec1[idx] : 1'b0;
      end
      return r;
   endfunction

   // Decoder: the second half of each bit carries the bit value.
   function automatic logic [7:0] bits_of(input int k, input int base);
      logic [7:0] r;
      int idx;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         idx = base + (2 * i + 1) * hlf(k);
         if (k == 0) r[7-i] = (idx < rec0.size()) ? rec0[idx] : 1'b0;
         else        r[7-i] = (idx < rec1.size()) ? rec1[idx] : 1'b0;
      end
      return r;
   endfunction

   initial begin
      int bad;
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      for (int k = 0; k < 2; k++) begin
         rst_a[k] = 1'b1; vld_a[k] = 1'b0; din_a[k] = 8'h00;
         pos[k] = -1; word[k] = 8'h00; mdone[k] = 1'b0;
         acc_n[k] = 0; acc_edge[k] = 0; tx_cnt[k] = 0; tx_rel[k] = 0;
      end

      repeat (2) cycle();
      check("reset dataout", 32'(out_a[0]), 32'd0);
      check("reset busy", 32'(busy_a[0]), 32'd0);
      check("reset tx_done", 32'(done_a[0]), 32'd0);
      check("reset din_ready", 32'(rdy_a[0]), 32'd0);
      rst_a[0] = 1'b0;
      rst_a[1] = 1'b0;
      cycle();
      check("idle din_ready", 32'(rdy_a[0]), 32'd1);

      // Single word 0xA5
      rec0.delete(); tx_cnt[0] = 0;
      send(0, 8'hA5, 1'b0);
      idle_wait(0);
      check("A5 length", rec0.size(), 64);
      check("A5 halves", 32'(halves_of(0, 0)), 32'h6699);
      check("A5 tx_done count", tx_cnt[0], 1);
      check("A5 tx_done cycle", tx_rel[0], 65);
      check("A5 idle line", 32'(out_a[0]), 32'd0);

      // Back-to-back 0x00 then 0xFF
      rec0.delete(); tx_cnt[0] = 0;
      send(0, 8'h00, 1'b1);
      send(0, 8'hFF, 1'b0);
      idle_wait(0);
      check("b2b length", rec0.size(), 128);
      check("b2b 00 halves", 32'(halves_of(0, 0)), 32'hAAAA);
      check("b2b FF halves", 32'(halves_of(0, 64)), 32'h5555);
      check("b2b tx_done count", tx_cnt[0], 2);

      // Reset mid-word, then 0x81
      tx_cnt[0] = 0;
      send(0, 8'h3C, 1'b0);
      repeat (19) cycle();
      rst_a[0] = 1'b1;
      cycle();
      check("abort dataout", 32'(out_a[0]), 32'd0);
      check("abort busy", 32'(busy_a[0]), 32'd0);
      rst_a[0] = 1'b0;
      cycle();
      check("abort din_ready", 32'(rdy_a[0]), 32'd1);
      repeat (70) cycle();
      check("abort no tx_done", tx_cnt[0], 0);
      rec0.delete();
      send(0, 8'h81, 1'b0);
      idle_wait(0);
      check("81 decode", 32'(bits_of(0, 0)), 32'h81);
      check("81 tx_done count", tx_cnt[0], 1);

      // din changes while busy with din_valid low
      rec0.delete(); tx_cnt[0] = 0;
      send(0, 8'h5A, 1'b0);
      din_a[0] = 8'hFF;
      repeat (10) cycle();
      din_a[0] = 8'h12;
      idle_wait(0);
      repeat (10) cycle();
      check("hold decode", 32'(bits_of(0, 0)), 32'h5A);
      check("hold tx_done count", tx_cnt[0], 1);
      check("hold no restart", 32'(busy_a[0]), 32'd0);

      // CLK_PER_HALF = 1
      rec1.delete(); tx_cnt[1] = 0;
      send(1, 8'h55, 1'b0);
      idle_wait(1);
      check("55 length", rec1.size(), 16);
      check("55 halves", 32'(halves_of(1, 0)), 32'h9999);
      check("55 tx_done cycle", tx_rel[1], 17);
      check("55 tx_done count", tx_cnt[1], 1);

      // Loopback decode of 0xC3
      rec0.delete();
      send(0, 8'hC3, 1'b0);
      idle_wait(0);
      check("C3 decode", 32'(bits_of(0, 0)), 32'hC3);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (rec0.size() >= 64 && rec0[i*8] == rec0[i*8+4]) bad++;
      end
      check("C3 mid-bit transitions", bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
